gpu_pixel_writeback: RTL and testbench
======================================

Name: gpu_pixel_writeback

Overview:
- Sits directly downstream of the texture/CLUT pipe controller and consumes its stage-2 pixel stream (valid, screen X/Y, texel, transparent flag, BG mask, vertex RGB, new-line flag).
- Per pixel: applies texture modulation, the mask-bit test and mask forcing.
- Accumulates surviving pixels into one 16-pixel (32-byte) VRAM cache-line buffer with per-pixel enables.
- Flushes the line to the memory arbiter, pausing the upstream pipe while a flush is outstanding.

Parameters:
- TEXMOD_EN, 1, 1 = modulate texel by vertex colour; 0 = texel always passed raw (GPU_REG_TexModRaw ignored).

Ports:
- clk  in  1  clock
- i_nrst  in  1  synchronous active-low reset
- GPU_REG_CheckMaskBit  in  1  drop pixel when destination mask bit is set
- GPU_REG_ForcePixel15MaskSet  in  1  force bit 15 of written pixel to 1
- GPU_REG_TexModRaw  in  1  raw texture (no modulation)
- GPU_TEX_DISABLE  in  1  primitive untextured
- i_newBGCacheLine  in  2  nonzero = primitive boundary pending
- i_validPixel  in  1  stage-2 pixel valid
- i_scrX  in  10  screen X
- i_scrY  in  9  screen Y
- i_texel  in  16  texel (BGR555 + bit15)
- i_transparent  in  1  texel fully transparent
- i_bgMsk  in  1  destination pixel mask bit
- i_R / i_G / i_B  in  9 each  vertex colour
- i_flushAll  in  1  level: push out partial line (end of primitive)
- o_pause  out  1  stall upstream pipe
- o_resetLineFlag  out  1  one-cycle clear of upstream new-line flag
- o_flushReq  out  1  line write request
- o_flushAdr  out  15  {Y[8:0], X[9:4]}
- o_flushData  out  256  pixel k at [16k+15:16k]
- o_flushBE  out  16  per-pixel write enable
- i_flushAck  in  1  one-cycle accept of request
- o_idle  out  1  ACCUM state, line empty, no request

Behaviour:
- Reset values (i_nrst low at a clk edge):
  - state = ACCUM; lineValid = 0; BE = 0; lineAdr = 0; data = 0.
  - o_pause = 0; o_flushReq = 0; o_resetLineFlag = 0; o_idle = 1.
  - Reset during FLUSH abandons the request without waiting for ack.
- Colour, per 5-bit channel (t = texel field, c = 9-bit vertex colour):
  - Untextured: min(31, c>>3).
  - Textured and (raw or !TEXMOD_EN): t.
  - Otherwise: min(31, (t*c)>>7), using a 14-bit product.
  - Bit 15 = (textured ? i_texel[15] : 0) | ForcePixel15MaskSet.
- Drop rule: a pixel is dropped when !i_validPixel, or (textured & i_transparent), or (CheckMaskBit & i_bgMsk). A dropped pixel never triggers a flush.
- Line match: lineAdr == {i_scrY, i_scrX[9:4]}. Slot index = i_scrX[3:0].
- ACCUM state, in priority order each cycle:
  1. i_newBGCacheLine != 0 with BE != 0: o_pause = 1, next state FLUSH.
  2. i_newBGCacheLine != 0 with BE == 0: o_resetLineFlag = 1 for this cycle. A non-dropped pixel is written in the same cycle.
  3. Non-dropped pixel, lineValid, no line match: o_pause = 1 (combinational), next state FLUSH. The pixel is held stable by the paused upstream.
  4. Non-dropped pixel, otherwise: write slot, set BE[slot], set lineValid, latch lineAdr. Same-slot rewrite overwrites (last wins). o_pause = 0.
  5. No pixel present, i_flushAll, BE != 0: next state FLUSH. i_flushAll with BE == 0 does nothing.
- FLUSH state:
  - o_flushReq = 1; o_pause = 1.
  - Adr, data and BE are stable until ack.
  - On i_flushAck: clear BE, lineValid = 0, next state ACCUM. The held pixel is accepted in the following cycle.
- Latency:
  - Accepted pixel appears in the line buffer 1 cycle after acceptance.
  - Conflict at cycle N gives o_flushReq at N+1.
  - Ack at M gives pause low at M+1, provided no new conflict.
- Line full (all 16 BE set): no automatic flush. The line flushes only on conflict, boundary or i_flushAll.
- o_flushReq is never asserted with BE == 0.

Test Plan:
- Modulation: untextured R = 255 -> 31. Textured t = 16, c = 128 -> 16; t = 31, c = 255 -> 31 (saturated); TexModRaw t = 7, c = 0 -> 7.
- Accumulate/flush: pixels X = 32..47, Y = 5, then X = 48 -> o_pause high, o_flushReq next cycle with o_flushAdr = {9'd5, 6'd2} and BE = FFFF. Ack -> X = 48 written, BE = 0001.
- Drop: CheckMaskBit = 1, i_bgMsk = 1 on a pixel of another line -> no flush, BE unchanged. Textured transparent pixel -> dropped.
- Boundary: i_newBGCacheLine = 1 with BE = 0x0003 -> flush, then o_resetLineFlag one cycle. With BE = 0 -> o_resetLineFlag the same cycle, no flush.
- Flush-all: two pixels in line, then idle + i_flushAll -> request with BE = 0x0003; after ack, o_idle = 1. Force mask set -> data bit 15 = 1.
- Reset mid-FLUSH: i_nrst low while o_flushReq = 1 and no ack -> next cycle o_flushReq = 0, o_pause = 0, o_idle = 1.

Source files
------------

// File: rtl/gpu_pixel_writeback.sv
// GPU pixel writeback: colour modulation, mask test and
// 16-pixel VRAM line accumulation with flush to the arbiter.
module gpu_pixel_writeback #(
  parameter bit TEXMOD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         i_nrst,
  input  logic         GPU_REG_CheckMaskBit,
  input  logic         GPU_REG_ForcePixel15MaskSet,
  input  logic         GPU_REG_TexModRaw,
  input  logic         GPU_TEX_DISABLE,
  input  logic [1:0]   i_newBGCacheLine,
  input  logic         i_validPixel,
  input  logic [9:0]   i_scrX,
  input  logic [8:0]   i_scrY,
  input  logic [15:0]  i_texel,
  input  logic         i_transparent,
  input  logic         i_bgMsk,
  input  logic [8:0]   i_R,
  input  logic [8:0]   i_G,
  input  logic [8:0]   i_B,
  input  logic         i_flushAll,
  output logic         o_pause,
  output logic         o_resetLineFlag,
  output logic         o_flushReq,
  output logic [14:0]  o_flushAdr,
  output logic [255:0] o_flushData,
  output logic [15:0]  o_flushBE,
  input  logic         i_flushAck,
  output logic         o_idle
);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t         state_q, state_d;
  logic           lv_q, lv_d;
  logic [15:0]    be_q, be_d;
  logic [14:0]    adr_q, adr_d;
  logic [255:0]   data_q, data_d;

  logic           tex;
  logic           drop;
  logic           hit;
  logic           wr;
  logic [3:0]     slot;
  logic [14:0]    pixAdr;
  logic [15:0]    pix;

  function automatic logic [4:0] chan(
    input logic [4:0] t,
    input logic [8:0] c,
    input logic       tx,
    input logic       raw
  );
    logic [13:0] p;
    logic [5:0]  u;
    u = c[8:3];
    p = {9'd0, t} * {5'd0, c};
    if (!tx)
      chan = (u > 6'd31) ? 5'd31 : u[4:0];
    else if (raw || !TEXMOD_EN)
      chan = t;
    else
      chan = (p[13:7] > 7'd31) ? 5'd31 : p[11:7];
  endfunction

  // Pixel colour, drop decision and line match.
  always_comb begin
    tex    = !GPU_TEX_DISABLE;
    pix    = {(tex & i_texel[15]) | GPU_REG_ForcePixel15MaskSet,
              chan(i_texel[14:10], i_B, tex, GPU_REG_TexModRaw),
              chan(i_texel[9:5],   i_G, tex, GPU_REG_TexModRaw),
              chan(i_texel[4:0],   i_R, tex, GPU_REG_TexModRaw)};
    drop   = !i_validPixel
           | (tex & i_transparent)
           | (GPU_REG_CheckMaskBit & i_bgMsk);
    pixAdr = {i_scrY, i_scrX[9:4]};
    slot   = i_scrX[3:0];
    hit    = (adr_q == pixAdr);
  end

  // Next-state, line buffer update and handshake outputs.
  always_comb begin
    state_d         = state_q;
    lv_d            = lv_q;
    be_d            = be_q;
    adr_d           = adr_q;
    data_d          = data_q;
    o_pause         = 1'b0;
    o_resetLineFlag = 1'b0;
    o_flushReq      = 1'b0;
    wr              = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (|i_newBGCacheLine && |be_q) begin
          o_pause = 1'b1;
          state_d = FLUSH;
        end else if (|i_newBGCacheLine) begin
          o_resetLineFlag = 1'b1;
          wr              = !drop;
        end else if (!drop && lv_q && !hit) begin
          o_pause = 1'b1;
          state_d = FLUSH;
        end else if (!drop) begin
          wr = 1'b1;
        end else if (i_flushAll && |be_q) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        o_flushReq = 1'b1;
        o_pause    = 1'b1;
        if (i_flushAck) begin
          be_d    = '0;
          lv_d    = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    if (wr) begin
      data_d[{slot, 4'b0000} +: 16] = pix;
      be_d[slot] = 1'b1;
      lv_d       = 1'b1;
      adr_d      = pixAdr;
    end
  end

  // State and line buffer registers.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      state_q <= ACCUM;
      lv_q    <= 1'b0;
      be_q    <= '0;
      adr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lv_q    <= lv_d;
      be_q    <= be_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
    end
  end

  assign o_flushAdr  = adr_q;
  assign o_flushData = data_q;
  assign o_flushBE   = be_q;
  assign o_idle      = (state_q == ACCUM) && (be_q == '0);

endmodule

// File: tb/tb_gpu_pixel_writeback.sv
// Directed bench for gpu_pixel_writeback.
// Hand-computed vectors checked with immediate assertions.
module tb_gpu_pixel_writeback;

  logic         clk = 1'b0;
  logic         nrst;
  logic         chkMask, force15, texRaw, texDis;
  logic [1:0]   newBG;
  logic         valid;
  logic [9:0]   x;
  logic [8:0]   y;
  logic [15:0]  texel;
  logic         transp, bgMsk;
  logic [8:0]   r, g, b;
  logic         flushAll;
  logic         pause, rlf, req;
  logic [14:0]  adr;
  logic [255:0] data;
  logic [15:0]  be;
  logic         ack;
  logic         idle;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpu_pixel_writeback #(.TEXMOD_EN(1'b1)) dut (
    .clk                        (clk),
    .i_nrst                     (nrst),
    .GPU_REG_CheckMaskBit       (chkMask),
    .GPU_REG_ForcePixel15MaskSet(force15),
    .GPU_REG_TexModRaw          (texRaw),
    .GPU_TEX_DISABLE            (texDis),
    .i_newBGCacheLine           (newBG),
    .i_validPixel               (valid),
    .i_scrX                     (x),
    .i_scrY                     (y),
    .i_texel                    (texel),
    .i_transparent              (transp),
    .i_bgMsk                    (bgMsk),
    .i_R                        (r),
    .i_G                        (g),
    .i_B                        (b),
    .i_flushAll                 (flushAll),
    .o_pause                    (pause),
    .o_resetLineFlag            (rlf),
    .o_flushReq                 (req),
    .o_flushAdr                 (adr),
    .o_flushData                (data),
    .o_flushBE                  (be),
    .i_flushAck                 (ack),
    .o_idle                     (idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic [9:0] px_x,
                    input logic [8:0] px_y);
    valid = 1'b1;
    x     = px_x;
    y     = px_y;
  endtask

  initial begin
    nrst = 1'b0; chkMask = 0; force15 = 0; texRaw = 0;
    texDis = 1; newBG = 0; valid = 0; x = 0; y = 0;
    texel = 0; transp = 0; bgMsk = 0; r = 0; g = 0; b = 0;
    flushAll = 0; ack = 0;
    tick(); tick();
    chk("rst_idle", idle, 1'b1);
    chk("rst_pause", pause, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_rlf", rlf, 1'b0);
    chk("rst_be", be, 16'h0);
    nrst = 1'b1;

    // modulation: untextured, modulated, raw
    r = 255; g = 0; b = 8; px(0, 0); tick();
    texDis = 0; texel = {1'b0, 5'd7, 5'd31, 5'd16};
    r = 128; g = 255; b = 0; px(1, 0); tick();
    texRaw = 1; texel = {1'b1, 5'd7, 5'd7, 5'd7};
    r = 0; g = 0; b = 0; px(2, 0); tick();
    valid = 0; texRaw = 0; texDis = 1;
    #1;
    chk("mod_untex", data[15:0], 16'h041F);
    chk("mod_tex", data[31:16], 16'h03F0);
    chk("mod_raw", data[47:32], 16'h9CE7);
    chk("mod_be", be, 16'h0007);
    flushAll = 1; tick();
    chk("fa0_req", req, 1'b1);
    chk("fa0_adr", adr, 15'd0);
    ack = 1; tick(); ack = 0; flushAll = 0;
    #1;
    chk("fa0_idle", idle, 1'b1);

    // accumulate a full line then conflict
    r = 255; g = 0; b = 0;
    for (int i = 32; i < 48; i++) begin
      px(i[9:0], 5); tick();
    end
    chk("acc_be", be, 16'hFFFF);
    chk("acc_adr", adr, {9'd5, 6'd2});
    px(48, 5);
    #1;
    chk("cf_pause", pause, 1'b1);
    chk("cf_req0", req, 1'b0);
    tick();
    chk("cf_req1", req, 1'b1);
    chk("cf_adr", adr, {9'd5, 6'd2});
    chk("cf_be", be, 16'hFFFF);
    tick();
    chk("cf_hold", req, 1'b1);
    ack = 1; tick(); ack = 0;
    #1;
    chk("cf_unpause", pause, 1'b0);
    chk("cf_req_lo", req, 1'b0);
    tick();
    valid = 0;
    chk("cf_new_be", be, 16'h0001);
    chk("cf_new_adr", adr, {9'd5, 6'd3});
    chk("cf_new_px", data[15:0], 16'h001F);

    // drops
    chkMask = 1; bgMsk = 1; px(100, 7);
    #1;
    chk("drp_msk_p", pause, 1'b0);
    tick();
    chk("drp_msk_be", be, 16'h0001);
    chk("drp_msk_rq", req, 1'b0);
    chkMask = 0; bgMsk = 0;
    texDis = 0; transp = 1; px(300, 8);
    #1;
    chk("drp_tr_p", pause, 1'b0);
    tick();
    chk("drp_tr_be", be, 16'h0001);
    texDis = 1; transp = 0;

    // boundary with data pending
    px(49, 5); tick(); valid = 0;
    chk("bnd_be", be, 16'h0003);
    newBG = 1;
    #1;
    chk("bnd_pause", pause, 1'b1);
    chk("bnd_rlf0", rlf, 1'b0);
    tick();
    chk("bnd_req", req, 1'b1);
    ack = 1; tick(); ack = 0;
    #1;
    chk("bnd_rlf1", rlf, 1'b1);
    chk("bnd_be0", be, 16'h0000);
    newBG = 0; tick();
    chk("bnd_rlf_lo", rlf, 1'b0);

    // boundary with empty line writes pixel same cycle
    newBG = 1; px(200, 9);
    #1;
    chk("bnd0_rlf", rlf, 1'b1);
    chk("bnd0_pause", pause, 1'b0);
    tick(); newBG = 0; valid = 0;
    chk("bnd0_be", be, 16'h0100);
    chk("bnd0_req", req, 1'b0);
    flushAll = 1; tick();
    ack = 1; tick(); ack = 0; flushAll = 0;
    #1;
    chk("bnd0_idle", idle, 1'b1);

    // flush-all with forced mask bit
    force15 = 1; r = 0; g = 0; b = 0;
    px(64, 3); tick();
    px(65, 3); tick();
    valid = 0; force15 = 0;
    flushAll = 1; tick();
    chk("fa_req", req, 1'b1);
    chk("fa_be", be, 16'h0003);
    chk("fa_adr", adr, {9'd3, 6'd4});
    chk("fa_mask", data[15:0], 16'h8000);
    ack = 1; tick(); ack = 0; flushAll = 0;
    #1;
    chk("fa_idle", idle, 1'b1);
    chk("fa_req_lo", req, 1'b0);

    // reset during flush
    px(10, 1); tick(); valid = 0;
    flushAll = 1; tick();
    chk("rf_req", req, 1'b1);
    nrst = 0; tick(); flushAll = 0;
    #1;
    chk("rf_req_lo", req, 1'b0);
    chk("rf_pause", pause, 1'b0);
    chk("rf_idle", idle, 1'b1);
    nrst = 1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
